// File: rtl/hue_duty_sequencer.sv
// Colour-wheel duty sequencer: walks six hue sectors, ramping one RGB channel
// per sector, and strobes update whenever the registered duties change.
module hue_duty_sequencer #(
  parameter int STEP_CYCLES = 7843,
  parameter int DUTY_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        sector,
  output logic              update
);

  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] MAX       = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] ZERO      = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] RAMP_LAST = MAX - DUTY_W'(1);

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_e;

  sector_e                r_sector;
  sector_e                w_sector_nxt;
  logic [PRE_W-1:0]       r_pre;
  logic [PRE_W-1:0]       w_pre_nxt;
  logic [DUTY_W-1:0]      r_ramp;
  logic [DUTY_W-1:0]      w_ramp_nxt;
  logic [DUTY_W-1:0]      r_duty_r;
  logic [DUTY_W-1:0]      r_duty_g;
  logic [DUTY_W-1:0]      r_duty_b;
  logic                   r_update;
  logic                   w_step;
  logic [3*DUTY_W-1:0]    w_duty_nxt;

  // Packed {R, G, B}; ramp never exceeds MAX-1 so the fall term cannot underflow.
  function automatic logic [3*DUTY_W-1:0] map_duty(input sector_e s,
                                                   input logic [DUTY_W-1:0] ramp);
    logic [DUTY_W-1:0] fall;
    fall = MAX - ramp;
    case (s)
      SEC_0:   map_duty = {MAX,  ramp, ZERO};
      SEC_1:   map_duty = {fall, MAX,  ZERO};
      SEC_2:   map_duty = {ZERO, MAX,  ramp};
      SEC_3:   map_duty = {ZERO, fall, MAX};
      SEC_4:   map_duty = {ramp, ZERO, MAX};
      SEC_5:   map_duty = {MAX,  ZERO, fall};
      default: map_duty = {MAX,  ZERO, ZERO};
    endcase
  endfunction

  // Next-state for prescaler, ramp and sector; duties follow the next state.
  always_comb begin
    w_step       = en && (r_pre == PRE_LAST);
    w_pre_nxt    = r_pre;
    w_ramp_nxt   = r_ramp;
    w_sector_nxt = r_sector;
    if (w_step) begin
      w_pre_nxt = PRE_W'(0);
      if (r_ramp < RAMP_LAST) begin
        w_ramp_nxt = r_ramp + DUTY_W'(1);
      end else begin
        w_ramp_nxt = ZERO;
        case (r_sector)
          SEC_0:   w_sector_nxt = SEC_1;
          SEC_1:   w_sector_nxt = SEC_2;
          SEC_2:   w_sector_nxt = SEC_3;
          SEC_3:   w_sector_nxt = SEC_4;
          SEC_4:   w_sector_nxt = SEC_5;
          SEC_5:   w_sector_nxt = SEC_0;
          default: w_sector_nxt = SEC_0;
        endcase
      end
    end else if (en) begin
      w_pre_nxt = r_pre + PRE_W'(1);
    end else begin
      w_pre_nxt = r_pre;
    end
    w_duty_nxt = map_duty(w_sector_nxt, w_ramp_nxt);
  end

  // Hue sector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sector <= SEC_0;
    end else begin
      r_sector <= w_sector_nxt;
    end
  end

  // Prescaler, ramp, registered duties and update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= PRE_W'(0);
      r_ramp   <= ZERO;
      r_duty_r <= MAX;
      r_duty_g <= ZERO;
      r_duty_b <= ZERO;
      r_update <= 1'b0;
    end else begin
      r_pre    <= w_pre_nxt;
      r_ramp   <= w_ramp_nxt;
      r_duty_r <= w_duty_nxt[3*DUTY_W-1:2*DUTY_W];
      r_duty_g <= w_duty_nxt[2*DUTY_W-1:DUTY_W];
      r_duty_b <= w_duty_nxt[DUTY_W-1:0];
      r_update <= w_step;
    end
  end

  assign duty_r = r_duty_r;
  assign duty_g = r_duty_g;
  assign duty_b = r_duty_b;
  assign sector = r_sector;
  assign update = r_update;

endmodule

// File: tb/tb_hue_duty_sequencer.sv
// Directed self-checking bench for hue_duty_sequencer (STEP_CYCLES=4 and 1, DUTY_W=3).
module tb_hue_duty_sequencer;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [2:0] duty_r, duty_g, duty_b, sector;
  logic       update;
  logic       rst2_n, en2;
  logic [2:0] d2_r, d2_g, d2_b, sector2;
  logic       update2;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  always #5 clk = ~clk;

  hue_duty_sequencer #(.STEP_CYCLES(SC), .DUTY_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .sector(sector), .update(update)
  );

  hue_duty_sequencer #(.STEP_CYCLES(1), .DUTY_W(3)) dut_cont (
    .clk(clk), .rst_n(rst2_n), .en(en2),
    .duty_r(d2_r), .duty_g(d2_g), .duty_b(d2_b),
    .sector(sector2), .update(update2)
  );

  // Expected {R,G,B} after kk steps from reset, MAX=7, 7 steps per sector.
  function automatic logic [8:0] exp_rgb(input int kk);
    int s, r;
    s = (kk / 7) % 6;
    r = kk % 7;
    case (s)
      0:       return {3'd7, 3'(r), 3'd0};
      1:       return {3'(7 - r), 3'd7, 3'd0};
      2:       return {3'd0, 3'd7, 3'(r)};
      3:       return {3'd0, 3'(7 - r), 3'd7};
      4:       return {3'(r), 3'd0, 3'd7};
      default: return {3'd7, 3'd0, 3'(7 - r)};
    endcase
  endfunction

  task automatic do_step();
    int         waited;
    bit         seen;
    int         nchg;
    bit         bad;
    int         d;
    logic [8:0] prev;
    logic [8:0] cur;
    prev   = {duty_r, duty_g, duty_b};
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 3 * SC; c++) begin
      @(negedge clk);
      waited++;
      if (update === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen || waited != SC) begin
      fails++;
      $display("FAIL step_spacing k=%0d: got %0d cycles (seen=%0d), required %0d", k, waited, seen, SC);
    end
    if (seen) k++;
    cur = {duty_r, duty_g, duty_b};
    tests++;
    if (cur !== exp_rgb(k) || sector !== 3'((k / 7) % 6)) begin
      fails++;
      $display("FAIL step_duty k=%0d: got rgb=%h sector=%0d, required rgb=%h sector=%0d",
               k, cur, sector, exp_rgb(k), (k / 7) % 6);
    end
    nchg = 0;
    bad  = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      d = int'(cur[ch*3 +: 3]) - int'(prev[ch*3 +: 3]);
      if (d == 1 || d == -1) nchg++;
      else if (d != 0) bad = 1'b1;
    end
    tests++;
    if (nchg != 1 || bad) begin
      fails++;
      $display("FAIL one_channel k=%0d: prev=%h now=%h, required exactly one channel +/-1", k, prev, cur);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd0, 3'd0} || sector !== 3'd0 || update !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got rgb=%0d,%0d,%0d sector=%0d update=%b, required 7,0,0 0 0",
               duty_r, duty_g, duty_b, sector, update);
    end
  endtask

  task automatic test_first_steps();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    k     = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      tests++;
      if (update !== ((i % 4) == 0)) begin
        fails++;
        $display("FAIL first_update edge=%0d: got %b, required %b", i, update, (i % 4) == 0);
      end
      if ((i % 4) == 0) begin
        k++;
        tests++;
        if (duty_g !== 3'(i / 4) || duty_r !== 3'd7 || duty_b !== 3'd0) begin
          fails++;
          $display("FAIL first_duty edge=%0d: got %0d,%0d,%0d, required 7,%0d,0",
                   i, duty_r, duty_g, duty_b, i / 4);
        end
      end
    end
  endtask

  task automatic test_sector_boundary();
    while (k < 6) do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd6, 3'd0} || sector !== 3'd0) begin
      fails++;
      $display("FAIL boundary_s6: got %0d,%0d,%0d sector=%0d, required 7,6,0 0", duty_r, duty_g, duty_b, sector);
    end
    do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd7, 3'd0} || sector !== 3'd1) begin
      fails++;
      $display("FAIL boundary_s7: got %0d,%0d,%0d sector=%0d, required 7,7,0 1", duty_r, duty_g, duty_b, sector);
    end
    do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd6, 3'd7, 3'd0}) begin
      fails++;
      $display("FAIL boundary_s8: got %0d,%0d,%0d, required 6,7,0", duty_r, duty_g, duty_b);
    end
  endtask

  task automatic test_full_wrap();
    while (k < 41) do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd0, 3'd1} || sector !== 3'd5) begin
      fails++;
      $display("FAIL wrap_pre: got %0d,%0d,%0d sector=%0d, required 7,0,1 5", duty_r, duty_g, duty_b, sector);
    end
    do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd0, 3'd0} || sector !== 3'd0) begin
      fails++;
      $display("FAIL wrap_post: got %0d,%0d,%0d sector=%0d, required 7,0,0 0", duty_r, duty_g, duty_b, sector);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (update !== 1'b0 || {duty_r, duty_g, duty_b} !== {3'd7, 3'd0, 3'd0}) begin
        fails++;
        $display("FAIL hold_idle cycle=%0d: got update=%b rgb=%0d,%0d,%0d, required 0 7,0,0",
                 i, update, duty_r, duty_g, duty_b);
      end
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (update !== 1'b0) begin
      fails++;
      $display("FAIL hold_resume1: got update=%b, required 0", update);
    end
    @(negedge clk);
    tests++;
    if (update !== 1'b1 || duty_g !== 3'd1) begin
      fails++;
      $display("FAIL hold_resume2: got update=%b g=%0d, required 1 1", update, duty_g);
    end
    k++;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (update !== 1'b0 || duty_g !== 3'd1) begin
        fails++;
        $display("FAIL hold_stepcycle cycle=%0d: got update=%b g=%0d, required 0 1", i, update, duty_g);
      end
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (update !== 1'b1 || duty_g !== 3'd2) begin
      fails++;
      $display("FAIL hold_step_resume: got update=%b g=%0d, required 1 2", update, duty_g);
    end
    k++;
  endtask

  task automatic test_reset_mid_run();
    while (k < 65) do_step();
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd0, 3'd5, 3'd7} || sector !== 3'd3) begin
      fails++;
      $display("FAIL midrun_pre: got %0d,%0d,%0d sector=%0d, required 0,5,7 3", duty_r, duty_g, duty_b, sector);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({duty_r, duty_g, duty_b} !== {3'd7, 3'd0, 3'd0} || sector !== 3'd0 || update !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: got %0d,%0d,%0d sector=%0d update=%b, required 7,0,0 0 0",
               duty_r, duty_g, duty_b, sector, update);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++;
      if (update !== (i == 4) || duty_g !== ((i == 4) ? 3'd1 : 3'd0)) begin
        fails++;
        $display("FAIL midrun_restart edge=%0d: got update=%b g=%0d, required %b %0d",
                 i, update, duty_g, i == 4, (i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_continuous();
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tests++;
      if (update2 !== 1'b1 || d2_g !== 3'(i) || d2_r !== 3'd7 || d2_b !== 3'd0) begin
        fails++;
        $display("FAIL continuous edge=%0d: got update=%b rgb=%0d,%0d,%0d, required 1 7,%0d,0",
                 i, update2, d2_r, d2_g, d2_b, i);
      end
    end
    @(negedge clk);
    tests++;
    if (update2 !== 1'b1 || sector2 !== 3'd1 || {d2_r, d2_g, d2_b} !== {3'd7, 3'd7, 3'd0}) begin
      fails++;
      $display("FAIL continuous_sector: got update=%b sector=%0d rgb=%0d,%0d,%0d, required 1 1 7,7,0",
               update2, sector2, d2_r, d2_g, d2_b);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b1;
    en     = 1'b0;
    rst2_n = 1'b0;
    en2    = 1'b1;
    test_reset();
    test_first_steps();
    test_sector_boundary();
    test_full_wrap();
    test_enable_hold();
    test_reset_mid_run();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hue_duty_sequencer.md
# hue_duty_sequencer

Generates the colour-wheel duty-cycle values that drive the RGB PWM stage. It walks a 6-sector hue cycle, raising or lowering one channel per sector in linear ramps. It presents registered `DUTY_W`-bit duty values for red, green and blue to the downstream PWM/RGB controller, together with a one-cycle `update` strobe whenever the values change. It sits directly upstream of the PWM stage and holds all hue timing.

## Interface
- `STEP_CYCLES`, default 7843: enabled clock cycles per ramp step. With a 12 MHz clock this gives about 1 s per full wheel when `DUTY_W`=8. Must be ≥1.
- `DUTY_W`, default 8: duty value width. `MAX` = 2^`DUTY_W`−1. Must be ≥2.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset; assertion immediately forces the reset state, and release is sampled on `clk`.
- `en`  input  1  advance enable; when low, all state holds.
- `duty_r`  output  `DUTY_W`  red duty, registered.
- `duty_g`  output  `DUTY_W`  green duty, registered.
- `duty_b`  output  `DUTY_W`  blue duty, registered.
- `sector`  output  3  current hue sector, 0–5, registered.
- `update`  output  1  one-cycle pulse on the cycle the duty outputs take new values.

## Operation
- State consists of:
  - prescaler `pre`, width max(1, $clog2(`STEP_CYCLES`));
  - ramp counter `ramp`, `DUTY_W` bits, range 0..`MAX`−1;
  - sector register, 3 bits, range 0..5.
- Step condition: `en`=1 and `pre`==`STEP_CYCLES`−1.
- When `en`=1 and there is no step: `pre` increments, and nothing else changes.
- On a step:
  - `pre` goes to 0.
  - If `ramp`<`MAX`−1, `ramp` increments.
  - Otherwise `ramp` goes to 0 and the sector advances. Sector 5 wraps to 0.
- When `en`=0: `pre`, `ramp`, sector and duties hold, and `update`=0. A partially counted prescale interval resumes where it stopped.
- Duty mapping, with rise=`ramp` and fall=`MAX`−`ramp`, as (R, G, B) per sector:
  - Sector 0: (`MAX`, rise, 0)
  - Sector 1: (fall, `MAX`, 0)
  - Sector 2: (0, `MAX`, rise)
  - Sector 3: (0, fall, `MAX`)
  - Sector 4: (rise, 0, `MAX`)
  - Sector 5: (`MAX`, 0, fall)
- The mapping gives continuous colour across every sector boundary, including the 5→0 wrap. Exactly one channel changes by exactly 1 per step.
- Duty registers load the mapping of the next-state `ramp`/sector on the step edge. Duties therefore always equal the mapping of the current `ramp`/sector.
- One full wheel is 6·`MAX` steps. At defaults that is 1530 steps = 11,999,790 cycles.
- Arithmetic is unsigned. `MAX`−`ramp` never underflows because `ramp`≤`MAX`−1.

## Timing
- Reset values:
  - `pre`=0, `ramp`=0, `sector`=0;
  - `duty_r`=`MAX`, `duty_g`=0, `duty_b`=0;
  - `update`=0.
- After reset release with `en` held high, the first step edge is the `STEP_CYCLES`-th rising edge. On that edge the duties, `sector` and `update`=1 all become visible together.
- `update` is high for exactly the cycle following a step edge. It deasserts on the next edge unless another step occurs.
- With `STEP_CYCLES`=1 and `en`=1, a step happens every cycle and `update` stays continuously high.
- Duty-to-output latency is zero beyond the register. The downstream PWM stage may sample on `update` or latch at its own period boundary. Duties never change more often than once per `STEP_CYCLES` enabled cycles.
- If `en` falls on the cycle a step would have occurred, there is no step. The step occurs on the first enabled cycle afterwards, because `pre` remains at `STEP_CYCLES`−1.
- Reset asserted mid-operation, including on a step cycle, immediately forces the reset values. No `update` pulse is produced for the interrupted step.

## Test plan
- **Reset:** `STEP_CYCLES`=4, `DUTY_W`=3 (`MAX`=7). Assert `rst_n`=0 asynchronously, between clock edges.
  - Required: outputs are immediately (7,0,0), `sector`=0, `update`=0.
- **First steps:** same parameters, release reset, `en`=1.
  - Required: `update` pulses after edges 4, 8, 12.
  - `duty_g` reads 1, 2, 3 while `duty_r`=7 and `duty_b`=0.
- **Sector boundary:** continue the run.
  - Required: after step 6, the duties are (7,6,0).
  - After step 7, `sector`=1 and the duties are (7,7,0).
  - After step 8, the duties are (6,7,0).
- **Full wrap:** run 42 steps.
  - Required: before step 42, `sector`=5 and the duties are (7,0,1).
  - After step 42, `sector`=0 and the duties are (7,0,0).
  - Every step changes exactly one channel by ±1.
- **Enable hold:**
  - Drop `en` after 2 enabled cycles and hold it low for 10 cycles. Required: no `update` pulse and duties unchanged; raising `en` again produces the step 2 cycles later.
  - Drop `en` exactly on a step cycle. Required: the step occurs on the first cycle `en` returns high.
- **Continuous and reset-mid-run:**
  - `STEP_CYCLES`=1. Required: `update` is held high and `duty_g` increments every cycle.
  - Pulse `rst_n` low mid-sector 3. Required: the block returns to (7,0,0), `sector`=0, and restarts cleanly.
